// File: rtl/m16_seq_approx_mul.sv
// m16_seq_approx_mul
//   Multi-cycle 16x16 approximate multiplier. One M8_5 8x8 approximate core is
//   time-shared over the four partial products LL, LH, HL, HH, which are
//   shift-accumulated into a 32-bit product (modulo 2^32).
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b sampled on accept only)
//   a, b                  16-bit multiplicand / multiplier
//   out_valid/out_ready   result handshake, y held while stalled
//   y                     32-bit approximate product
//   busy                  high whenever the controller is not idle
// Parameters
//   EXACT_HH   1: the HH step uses an exact 8x8 product instead of the core
//   ZERO_SKIP  1: steps whose operand half is zero are bypassed

// M8_5 approximate 8x8 core. Partial-product columns 0..4 are compressed
// with OR (no carries); columns 5..14 are summed exactly. Purely
// combinational; the result is 0 whenever either operand is 0.
module m8_5_core (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    logic [7:0][7:0]  pp_row;  // pp_row[i][j] = x[j] & y[i], column i+j
    logic [7:0][15:0] hi_row;  // row i with its low-column bits masked, shifted
    logic [4:0]       lo_col;

    for (genvar i = 0; i < 8; i++) begin : g_row
        localparam logic [7:0] HI_MASK = (i >= 5) ? 8'hFF : (8'hFF << (5 - i));
        assign pp_row[i] = x & {8{y[i]}};
        assign hi_row[i] = {8'b0, pp_row[i] & HI_MASK} << i;
    end

    assign lo_col[0] = pp_row[0][0];
    assign lo_col[1] = pp_row[0][1] | pp_row[1][0];
    assign lo_col[2] = pp_row[0][2] | pp_row[1][1] | pp_row[2][0];
    assign lo_col[3] = pp_row[0][3] | pp_row[1][2] | pp_row[2][1] | pp_row[3][0];
    assign lo_col[4] = pp_row[0][4] | pp_row[1][3] | pp_row[2][2] | pp_row[3][1]
                     | pp_row[4][0];

    // The masked high sum has no bits below column 5, so OR merges cleanly.
    assign p = (hi_row[0] + hi_row[1] + hi_row[2] + hi_row[3]
              + hi_row[4] + hi_row[5] + hi_row[6] + hi_row[7])
             | {11'b0, lo_col};
endmodule

module m16_seq_approx_mul #(
    parameter int EXACT_HH  = 0,
    parameter int ZERO_SKIP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LL   = 3'd1;
    localparam logic [2:0] S_LH   = 3'd2;
    localparam logic [2:0] S_HL   = 3'd3;
    localparam logic [2:0] S_HH   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] a_r_q, a_r_d;
    logic [15:0] b_r_q, b_r_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] y_q, y_d;
    logic        out_valid_q, out_valid_d;

    logic [15:0] op_a, op_b;
    logic [3:0]  need;          // {HH, HL, LH, LL} step has a nonzero product
    logic [7:0]  core_x, core_y;
    logic [15:0] core_p, pp;
    logic [4:0]  sh;
    logic [31:0] pp_sh;

    // First required step among those left in mask m, else DONE.
    function automatic logic [2:0] first_step(input logic [3:0] m);
        if (m[0])      return S_LL;
        else if (m[1]) return S_LH;
        else if (m[2]) return S_HL;
        else if (m[3]) return S_HH;
        else           return S_DONE;
    endfunction

    m8_5_core u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

    always_comb begin
        // In IDLE the skip decision is made on the operands being accepted.
        op_a = (state_q == S_IDLE) ? a : a_r_q;
        op_b = (state_q == S_IDLE) ? b : b_r_q;
        if (ZERO_SKIP != 0) begin
            need = {(|op_a[15:8]) & (|op_b[15:8]),
                    (|op_a[15:8]) & (|op_b[7:0]),
                    (|op_a[7:0])  & (|op_b[15:8]),
                    (|op_a[7:0])  & (|op_b[7:0])};
        end else begin
            need = 4'hF;
        end

        core_x = 8'h00;
        core_y = 8'h00;
        sh     = 5'd0;
        case (state_q)
            S_LL: begin core_x = a_r_q[7:0];  core_y = b_r_q[7:0];  sh = 5'd0;  end
            S_LH: begin core_x = a_r_q[7:0];  core_y = b_r_q[15:8]; sh = 5'd8;  end
            S_HL: begin core_x = a_r_q[15:8]; core_y = b_r_q[7:0];  sh = 5'd8;  end
            S_HH: begin core_x = a_r_q[15:8]; core_y = b_r_q[15:8]; sh = 5'd16; end
            default: ;
        endcase

        if ((EXACT_HH != 0) && (state_q == S_HH)) begin
            pp = {8'b0, a_r_q[15:8]} * {8'b0, b_r_q[15:8]};
        end else begin
            pp = core_p;
        end
        pp_sh = {16'b0, pp} << sh;

        state_d     = state_q;
        a_r_d       = a_r_q;
        b_r_d       = b_r_q;
        acc_d       = acc_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_r_d   = a;
                    b_r_d   = b;
                    acc_d   = 32'h0;
                    state_d = first_step(need);
                end
            end
            S_LL: begin
                acc_d   = acc_q + pp_sh;
                state_d = first_step(need & 4'b1110);
            end
            S_LH: begin
                acc_d   = acc_q + pp_sh;
                state_d = first_step(need & 4'b1100);
            end
            S_HL: begin
                acc_d   = acc_q + pp_sh;
                state_d = first_step(need & 4'b1000);
            end
            S_HH: begin
                acc_d   = acc_q + pp_sh;
                state_d = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle registers the result; afterwards wait for the consumer.
                if (!out_valid_q) begin
                    y_d         = acc_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_r_q       <= 16'h0;
            b_r_q       <= 16'h0;
            acc_q       <= 32'h0;
            y_q         <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_r_q       <= a_r_d;
            b_r_q       <= b_r_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
endmodule

// File: tb/tb_m16_seq_approx_mul.sv
// Bench for m16_seq_approx_mul. Three instances cover the parameter corners
// (EXACT_HH, ZERO_SKIP) = (0,0), (1,1), (0,1) and share one clock and reset.
module tb_m16_seq_approx_mul;
    localparam int NI = 3;
    localparam int N  = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic        busy      [NI];
    logic [15:0] a [NI];
    logic [15:0] b [NI];
    logic [31:0] y [NI];
    logic [31:0] sb [NI][N];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m16_seq_approx_mul #(.EXACT_HH(0), .ZERO_SKIP(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .y(y[0]), .busy(busy[0]));
    m16_seq_approx_mul #(.EXACT_HH(1), .ZERO_SKIP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .y(y[1]), .busy(busy[1]));
    m16_seq_approx_mul #(.EXACT_HH(0), .ZERO_SKIP(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .y(y[2]), .busy(busy[2]));

    function automatic bit eh(int k);
        return k == 1;
    endfunction

    function automatic bit zs(int k);
        return k != 0;
    endfunction

    // M8_5: exact product, with the exact contribution of columns 0..4
    // replaced by one bit per column that is set if any term there is 1.
    function automatic logic [15:0] c85(logic [7:0] x, logic [7:0] v);
        int ex, lo_ex, lo_or;
        ex    = int'(x) * int'(v);
        lo_ex = 0;
        lo_or = 0;
        for (int col = 0; col < 5; col++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i <= col; i++) begin
                if (x[i] && v[col - i]) begin
                    lo_ex += 1 << col;
                    any = 1'b1;
                end
            end
            if (any) lo_or += 1 << col;
        end
        return 16'(ex - lo_ex + lo_or);
    endfunction

    function automatic logic [31:0] m16(logic [15:0] av, logic [15:0] bv, bit exact_hh);
        logic [31:0] ll, lh, hl, hh;
        ll = {16'b0, c85(av[7:0],  bv[7:0])};
        lh = {16'b0, c85(av[7:0],  bv[15:8])};
        hl = {16'b0, c85(av[15:8], bv[7:0])};
        hh = exact_hh ? 32'(int'(av[15:8]) * int'(bv[15:8]))
                      : {16'b0, c85(av[15:8], bv[15:8])};
        return ll + (lh << 8) + (hl << 8) + (hh << 16);
    endfunction

    // Cycles from accept to out_valid: one per executed step, plus one.
    function automatic int exp_lat(int k, logic [15:0] av, logic [15:0] bv);
        int n;
        if (!zs(k)) return 5;
        n = 0;
        if (av[7:0]  != 0 && bv[7:0]  != 0) n++;
        if (av[7:0]  != 0 && bv[15:8] != 0) n++;
        if (av[15:8] != 0 && bv[7:0]  != 0) n++;
        if (av[15:8] != 0 && bv[15:8] != 0) n++;
        return n + 1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a pair and return at the negedge after the accept edge.
    task automatic send(int k, logic [15:0] av, logic [15:0] bv);
        int t;
        @(negedge clk);
        a[k] = av;
        b[k] = bv;
        in_valid[k] = 1'b1;
        t = 0;
        while (!in_ready[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 32'(t), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        a[k] = 16'($urandom);  // must be ignored mid-operation
        b[k] = 16'($urandom);
    endtask

    task automatic wait_out(int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Accept the pending result and check the block is idle on the next cycle.
    task automatic drain(int k, string tag);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk({tag, "_idle_rdy"}, 32'(in_ready[k]), 32'd1);
        chk({tag, "_idle_ov"}, 32'(out_valid[k]), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy[k]), 32'd0);
    endtask

    task automatic directed(int k, string tag, logic [15:0] av, logic [15:0] bv);
        int lat;
        send(k, av, bv);
        wait_out(k, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(k, av, bv)));
        chk({tag, "_y"}, y[k], m16(av, bv, eh(k)));
        drain(k, tag);
    endtask

    task automatic stream(int k);
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [15:0] av, bv;
                    av = 16'($urandom);
                    bv = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) av[7:0]  = 8'h00;
                    if ($urandom_range(0, 3) == 0) av[15:8] = 8'h00;
                    if ($urandom_range(0, 3) == 0) bv[7:0]  = 8'h00;
                    if ($urandom_range(0, 3) == 0) bv[15:8] = 8'h00;
                    sb[k][i] = m16(av, bv, eh(k));
                    send(k, av, bv);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                int got, cyc;
                got = 0;
                cyc = 0;
                while (got < N && cyc < 60000) begin
                    @(negedge clk);
                    out_ready[k] = 1'($urandom_range(0, 1));
                    if (out_valid[k] && out_ready[k]) begin
                        chk("t6_y", y[k], sb[k][got]);
                        got++;
                    end
                    cyc++;
                end
                chk("t6_count", 32'(got), 32'(N));
                @(negedge clk);
                out_ready[k] = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        chk("t6_no_dup", 32'(out_valid[k]), 32'd0);
    endtask

    initial begin
        int lat;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            a[k] = 16'h0;
            b[k] = 16'h0;
        end

        // 1: reset / idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk("t1_ov", 32'(out_valid[k]), 32'd0);
            chk("t1_y", y[k], 32'd0);
            chk("t1_rdy", 32'(in_ready[k]), 32'd1);
            chk("t1_busy", 32'(busy[k]), 32'd0);
        end

        // 2: zero operand, fixed latency; also a nonzero pair for comparison
        directed(0, "t2_zero", 16'h0000, 16'hFFFF);
        directed(0, "t2_nz", 16'hA5C3, 16'h3C5A);

        // 3: skip path
        for (int k = 1; k < NI; k++) begin
            directed(k, "t3_zero", 16'h0000, 16'h1234);
            directed(k, "t3_hh", 16'h0100, 16'h0100);
            directed(k, "t3_lh", 16'h0012, 16'h3400);
            directed(k, "t3_full", 16'hFFFF, 16'h8001);
        end

        // 4: backpressure
        for (int k = 0; k < NI; k++) begin
            send(k, 16'hFFFF, 16'hFFFF);
            wait_out(k, lat);
            chk("t4_lat", 32'(lat), 32'(exp_lat(k, 16'hFFFF, 16'hFFFF)));
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("t4_y", y[k], m16(16'hFFFF, 16'hFFFF, eh(k)));
                chk("t4_ov", 32'(out_valid[k]), 32'd1);
                chk("t4_rdy", 32'(in_ready[k]), 32'd0);
            end
            drain(k, "t4");
        end

        // 5: reset while in LH (second compute cycle) on the fixed-latency build
        send(0, 16'h00FF, 16'h00FF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rdy", 32'(in_ready[0]), 32'd1);
        chk("t5_y", y[0], 32'd0);
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid[0]) lat++;
            @(negedge clk);
        end
        chk("t5_ov_never", 32'(lat), 32'd0);
        directed(0, "t5_next", 16'h0003, 16'h0005);

        // 6: random streams on all instances concurrently
        fork
            stream(0);
            stream(1);
            stream(2);
        join

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
